// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, core redirect, and instruction output.
interface ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_err;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_pc, inst, inst_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc, inst_ready
    );

    // Memory / core side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_pc, inst, inst_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most DEPTH words in flight or buffered,
// matches in-order memory responses to their addresses and flushes stale fetches on redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    ifu_fetch_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } entry_t;

    logic [31:0]   fpc;
    logic [31:0]   pend_mem [DEPTH];
    logic [PW-1:0] pend_wp;
    logic [PW-1:0] pend_rp;
    logic [CW-1:0] pend_cnt;
    entry_t        out_mem [DEPTH];
    logic [PW-1:0] out_wp;
    logic [PW-1:0] out_rp;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;

    logic          inst_valid_c;
    logic          pop;
    logic [CW:0]   used;
    logic          req_valid_c;
    logic          req_fire;
    logic          rsp_fire;
    logic          keep;
    logic          redirect;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Handshake and credit decode; a pop frees a credit in the same cycle
    always_comb begin
        inst_valid_c = reset & (out_cnt != '0);
        pop          = inst_valid_c & bus.inst_ready;
        used         = (CW+1)'(pend_cnt) + (CW+1)'(out_cnt) - (CW+1)'(pop);
        req_valid_c  = reset & (used < (CW+1)'(DEPTH));
        req_fire     = req_valid_c & bus.imem_req_ready;
        rsp_fire     = reset & bus.imem_rsp_valid;
        redirect     = bus.redirect_valid;
        keep         = rsp_fire & ~redirect & (drop_cnt == '0);
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fpc;
    assign bus.inst_valid     = inst_valid_c;
    assign bus.inst_pc        = out_mem[out_rp].pc;
    assign bus.inst           = out_mem[out_rp].data;
    assign bus.inst_err       = out_mem[out_rp].err;

    // Control state: fetch PC, FIFO pointers and counters; redirect overrides everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            pend_wp  <= '0;
            pend_rp  <= '0;
            pend_cnt <= '0;
            out_wp   <= '0;
            out_rp   <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (redirect)
                fpc <= {bus.redirect_pc[31:2], 2'b00};
            else if (req_fire)
                fpc <= fpc + 32'd4;

            if (req_fire) pend_wp <= ptr_inc(pend_wp);
            if (rsp_fire) pend_rp <= ptr_inc(pend_rp);
            pend_cnt <= pend_cnt + CW'(req_fire) - CW'(rsp_fire);

            // Everything still outstanding after this edge is stale on redirect
            if (redirect)
                drop_cnt <= pend_cnt + CW'(req_fire) - CW'(rsp_fire);
            else if (rsp_fire && drop_cnt != '0)
                drop_cnt <= drop_cnt - CW'(1);

            if (redirect) begin
                out_wp  <= '0;
                out_rp  <= '0;
                out_cnt <= '0;
            end else begin
                if (keep) out_wp <= ptr_inc(out_wp);
                if (pop)  out_rp <= ptr_inc(out_rp);
                out_cnt <= out_cnt + CW'(keep) - CW'(pop);
            end
        end
    end

    // FIFO storage; contents need no reset since counters gate visibility
    always_ff @(posedge clk) begin
        if (req_fire)
            pend_mem[pend_wp] <= fpc;
        if (keep)
            out_mem[out_wp] <= '{pc: pend_mem[pend_rp], data: bus.imem_rsp_data, err: bus.imem_rsp_err};
    end

    // A response must always have a matching pending request
    always_ff @(posedge clk) begin
        if (reset && bus.imem_rsp_valid)
            assert (pend_cnt != '0);
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order fixed-latency instruction memory model.
module tb_ifu_fetch;
    logic clk;
    logic rst;
    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } pop_t;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       mq[$];
    pop_t        pops[$];
    int          cyc;
    int          lat;
    bit          err_en;
    logic [31:0] err_addr;
    int          errors;
    int          checks;

    logic        s_rv;
    logic [31:0] s_addr;
    logic        s_iv;
    logic [31:0] s_pc;
    logic [31:0] s_inst;
    logic        s_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and memory response at negedge, sample, then advance
    task automatic step(input bit rst_v, input bit rdy, input bit rdr, input logic [31:0] rpc);
        rst = rst_v;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = 1'b1;
        if (!rst_v) mq.delete();
        if (rst_v && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
            bus.imem_rsp_err   = err_en && (mq[0].addr == err_addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
            bus.imem_rsp_err   = 1'b0;
        end
        #1;
        s_rv   = bus.imem_req_valid;
        s_addr = bus.imem_req_addr;
        s_iv   = bus.inst_valid;
        s_pc   = bus.inst_pc;
        s_inst = bus.inst;
        s_err  = bus.inst_err;
        if (s_rv && bus.imem_req_ready) mq.push_back('{addr: s_addr, due: cyc + lat});
        if (s_iv && rdy) pops.push_back('{pc: s_pc, inst: s_inst, err: s_err});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic chk_pop(input string name, input int idx, input logic [31:0] pc, input logic err);
        chk({name, " count"}, 32'(pops.size() > idx), 32'd1);
        if (pops.size() > idx) begin
            chk({name, " pc"},   pops[idx].pc,   pc);
            chk({name, " inst"}, pops[idx].inst, mem_word(pc));
            chk({name, " err"},  32'(pops[idx].err), 32'(err));
        end
    endtask

    vec_t vecs[23];

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        lat    = 1;
        err_en = 1'b0;
        err_addr = 32'h0;
        rst = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;

        // Reset + zero-wait stream, then 1-cycle reset and 10-cycle output stall
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        for (int i = 11; i <= 18; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rst, vecs[i].rdy, 1'b0, 32'h0);
            chk($sformatf("v%0d req_valid", i), 32'(s_rv), 32'(vecs[i].rv));
            if (vecs[i].rv) chk($sformatf("v%0d req_addr", i), s_addr, vecs[i].addr);
            chk($sformatf("v%0d inst_valid", i), 32'(s_iv), 32'(vecs[i].iv));
            if (vecs[i].iv) begin
                chk($sformatf("v%0d inst_pc", i), s_pc, vecs[i].pc);
                chk($sformatf("v%0d inst", i), s_inst, mem_word(vecs[i].pc));
                chk($sformatf("v%0d inst_err", i), 32'(s_err), 32'd0);
            end
        end

        // Redirect with two requests outstanding, memory latency 3
        lat = 3;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        run(2);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0103);
        chk("s1 credit stall", 32'(s_rv), 32'd0);
        chk("s1 drop_cnt", 32'(dut.drop_cnt), 32'd2);
        pops.delete();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("s1 addr after redirect", s_addr, 32'h8000_0100);
        run(12);
        chk_pop("s1 pop0", 0, 32'h8000_0100, 1'b0);
        chk_pop("s1 pop1", 1, 32'h8000_0104, 1'b0);
        chk("s1 drop drained", 32'(dut.drop_cnt), 32'd0);

        // Redirect coinciding with request fire and response fire
        lat = 1;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        run(5);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0200);
        chk("s2 req fire at redirect", 32'(s_rv), 32'd1);
        chk("s2 drop_cnt", 32'(dut.drop_cnt), 32'd1);
        pops.delete();
        run(10);
        chk_pop("s2 pop0", 0, 32'h8000_0200, 1'b0);
        chk_pop("s2 pop1", 1, 32'h8000_0204, 1'b0);
        chk_pop("s2 pop2", 2, 32'h8000_0208, 1'b0);
        chk("s2 drop drained", 32'(dut.drop_cnt), 32'd0);

        // Access fault on one fetch only
        err_en   = 1'b1;
        err_addr = 32'h8000_0008;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        pops.delete();
        run(8);
        chk_pop("s3 pop0", 0, 32'h8000_0000, 1'b0);
        chk_pop("s3 pop1", 1, 32'h8000_0004, 1'b0);
        chk_pop("s3 pop2", 2, 32'h8000_0008, 1'b1);
        chk_pop("s3 pop3", 3, 32'h8000_000C, 1'b0);

        // Address wrap, then single-cycle mid-run reset
        err_en = 1'b0;
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        pops.delete();
        run(10);
        chk_pop("s4 pop0", 0, 32'hFFFF_FFF8, 1'b0);
        chk_pop("s4 pop1", 1, 32'hFFFF_FFFC, 1'b0);
        chk_pop("s4 pop2", 2, 32'h0000_0000, 1'b0);
        chk_pop("s4 pop3", 3, 32'h0000_0004, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4 req_valid in reset", 32'(s_rv), 32'd0);
        chk("s4 inst_valid in reset", 32'(s_iv), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("s4 restart req_valid", 32'(s_rv), 32'd1);
        chk("s4 restart addr", s_addr, 32'h8000_0000);
        chk("s4 restart empty", 32'(s_iv), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("s4 second addr", s_addr, 32'h8000_0004);
        chk("s4 still empty", 32'(s_iv), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("s4 first valid", 32'(s_iv), 32'd1);
        chk("s4 first pc", s_pc, 32'h8000_0000);
        chk("s4 drop_cnt", 32'(dut.drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage placed directly upstream of the single-cycle RV32 execute core. It owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, and matches in-order responses to their addresses. It buffers fetched words in a small FIFO and presents `{pc, inst}` to the core with a valid/ready handshake. A redirect from the core (jal/jalr target) flushes buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h80000000: first fetch address after reset.
- `DEPTH`, default 2, minimum 2: capacity of the output FIFO and the maximum number of in-flight requests.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `imem_req_valid`, out, 1: fetch request.
- `imem_req_ready`, in, 1: memory accepts the request.
- `imem_req_addr`, out, 32: word address; bits [1:0] are always 0.
- `imem_rsp_valid`, in, 1: response beat. Responses arrive in order, at least 1 cycle after acceptance, and are always accepted.
- `imem_rsp_data`, in, 32: instruction word.
- `imem_rsp_err`, in, 1: access fault.
- `redirect_valid`, in, 1: flush and restart fetch.
- `redirect_pc`, in, 32: new fetch PC; bits [1:0] are ignored and treated as 0.
- `inst_valid`, out, 1: FIFO head valid.
- `inst_ready`, in, 1: core consumes the head.
- `inst_pc`, out, 32: PC of the head entry.
- `inst`, out, 32: instruction word of the head entry.
- `inst_err`, out, 1: fault flag of the head entry.

## Operation
**State**
- `fpc`: fetch PC.
- Pending-address FIFO: `DEPTH` entries.
- Output FIFO: `DEPTH` entries of {pc, data, err}.
- `pend_cnt`, `out_cnt`, `drop_cnt`: each `$clog2(DEPTH+1)` bits.

**Request path**
- Credit rule: `imem_req_valid = reset & (pend_cnt + out_cnt - pop < DEPTH)`, where `pop = inst_valid & inst_ready`.
- `req_valid` therefore depends combinationally on `inst_ready`. It does not depend on `redirect_valid`.
- `imem_req_addr = fpc`.
- Request fire (valid & ready):
  - push `fpc` into the pending FIFO;
  - `fpc <= fpc + 4`, modulo 2^32, so 32'hFFFFFFFC wraps to 0.

**Response path**
- Each response pops the pending FIFO.
- If `drop_cnt != 0`: the response is discarded and `drop_cnt` decrements.
- Otherwise: push {popped addr, `rsp_data`, `rsp_err`} into the output FIFO.
- The credit rule guarantees the output FIFO never overflows.
- A response with no pending entry is illegal; assert in simulation.

**Output**
- `inst_valid = (out_cnt != 0)`.
- `inst_pc`, `inst`, `inst_err` come from the FIFO head.
- A pop occurs on `inst_valid & inst_ready`.

**Redirect (highest priority)**
- `fpc <= {redirect_pc[31:2], 2'b00}`.
- The output FIFO is emptied, and a pop in the same cycle has no additional effect.
- `drop_cnt <= pend_cnt + req_fire - rsp_fire`. All requests still outstanding become stale, including one accepted in the redirect cycle.
- A response arriving in the redirect cycle is discarded regardless of `drop_cnt`.
- Redirect while `drop_cnt != 0` uses the same formula, because `pend_cnt` already counts the earlier stale requests.
- `imem_req_addr` may change in the redirect cycle even while a request is stalled (`valid & !ready`). The memory interface permits this. Otherwise `addr` is held stable while stalled.

**Reset**
- While `reset == 0`, the outputs `imem_req_valid` and `inst_valid` are 0, and responses are ignored.
- On the first edge with `reset == 0`: `fpc = RESET_PC`, all counts are 0, and both FIFOs are empty.
- Instruction memory shares this reset. Nothing is in flight after reset, including resets asserted mid-operation.

## Timing
- Request accepted in cycle N, response in cycle N+k (k ≥ 1), `inst_valid` in cycle N+k+1 (FIFO write is registered).
- Zero-wait memory (`ready` = 1, k = 1) with `inst_ready` = 1:
  - one instruction per cycle sustained after 2 cycles of fill latency;
  - first `inst_valid` 2 cycles after reset release.
- Output stall (`inst_ready` = 0): requests stop once `pend_cnt + out_cnt == DEPTH`, and resume in the same cycle as the next pop.
- Redirect in cycle R: a new-target request can fire in R+1, and its instruction appears at R+3 or later after all stale responses drain.
- Counter sizing: `pend_cnt` ≤ `DEPTH`, `out_cnt` ≤ `DEPTH`, `drop_cnt` ≤ `pend_cnt` at all times.

## Test plan
- **Reset, zero-wait memory, `inst_ready` = 1:** `inst_pc` sequence is 80000000, 80000004, 80000008… on consecutive cycles. First valid arrives 2 cycles after `reset` rises.
- **Output backpressure:** hold `inst_ready` = 0 for 10 cycles. Exactly `DEPTH` = 2 requests are issued, `inst_valid` stays 1 with `inst_pc` = 80000000, and no word is lost or duplicated after release.
- **Redirect with 2 outstanding (memory latency 3):** `redirect_pc` = 80000103. The two stale responses are discarded. The next `inst_pc` is 80000100, and `imem_req_addr` is 80000100 in the cycle after the redirect.
- **Redirect coinciding with response and request fire:** no stale instruction ever reaches `inst_valid`, and `drop_cnt` returns to 0.
- **Access fault:** `imem_rsp_err` = 1 on the fetch of 80000008. `inst_err` = 1 only on the entry with `inst_pc` = 80000008.
- **Wrap and mid-run reset:** redirect to FFFFFFF8 yields `inst_pc` FFFFFFF8, FFFFFFFC, 00000000. Asserting `reset` for 1 cycle then restarts fetch at 80000000 with empty state.
